// File: rtl/seq_divider4_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider4_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Quotient reported when the divisor is zero (default width).
  localparam logic [DEF_WIDTH-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/seq_divider4_div_sub_stage.sv
// Combinational W+1-bit subtractor: d = a - b via a + ~b + 1.
module div_sub_stage #(
  parameter int W = 4
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] d,
  output logic       no_borrow
);

  logic [W+1:0] sum;

  // Carry-out of the two's-complement add is the inverted borrow.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, ~b} + (W+2)'(1);
    d         = sum[W:0];
    no_borrow = sum[W+1];
  end

endmodule

// File: rtl/seq_divider4.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_divider4
  import seq_divider4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH:0]   p, t, d, p_nxt;
  logic [WIDTH-1:0] q, dv, q_nxt;
  logic [CW-1:0]    cnt;
  logic             nob, accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Shift the next dividend bit into the partial remainder. P stays below
  // the divisor, so its top bit is always clear and the truncation is safe.
  assign t = (WIDTH+1)'({p, q[WIDTH-1]});

  div_sub_stage #(.W(WIDTH)) u_sub (
    .a        (t),
    .b        ({1'b0, dv}),
    .d        (d),
    .no_borrow(nob)
  );

  assign p_nxt = nob ? d : t;
  assign q_nxt = {q[WIDTH-2:0], nob};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: accept from IDLE/DONE, WIDTH iterations in RUN, one-cycle DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-subtract iteration, result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      p         <= '0;
      q         <= '0;
      dv        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      divzero   <= 1'b0;
    end else if (accept) begin
      p   <= '0;
      q   <= dividend;
      dv  <= divisor;
      cnt <= '0;
      if (divisor == '0) begin
        quotient  <= {WIDTH{1'b1}};
        remainder <= dividend;
        divzero   <= 1'b1;
      end else begin
        divzero   <= 1'b0;
      end
    end else if (state == RUN) begin
      p   <= p_nxt;
      q   <= q_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient  <= q_nxt;
        remainder <= WIDTH'(p_nxt);
      end
    end
  end

endmodule

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4: arithmetic reference model + directed cases.
module tb_seq_divider4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         resetn, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, divzero;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  seq_divider4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .divzero  (divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a cycle countdown plus plain / and %.
  int m_cnt = 0;
  int m_q = 0, m_r = 0, pend_q = 0, pend_r = 0;
  bit m_done = 0, m_dz = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_cnt = 0; m_done = 0; m_q = 0; m_r = 0; m_dz = 0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1; m_q = pend_q; m_r = pend_r;
      end
    end else begin
      m_done = 0;
      if (start) begin
        if (divisor == 0) begin
          m_done = 1; m_q = 15; m_r = int'(dividend); m_dz = 1;
        end else begin
          m_dz = 0;
          pend_q = int'(dividend) / int'(divisor);
          pend_r = int'(dividend) % int'(divisor);
          m_cnt = W;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_cnt != 0));
      chk("done", int'(done), int'(m_done));
      chk("divzero", int'(divzero), int'(m_dz));
      chk("quotient", int'(quotient), m_q);
      chk("remainder", int'(remainder), m_r);
      if (busy && done) chk("busy_and_done", 1, 0);
    end
  end

  // Pulse start for one cycle, then wait (bounded) for done.
  task automatic run_div(input int a, input int b, output int lat, output int nbusy);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  task automatic div_lit(input int a, input int b, input int eq, input int er,
                         input int edz, input int elat, input int ebusy);
    int lat, nb;
    run_div(a, b, lat, nb);
    chk("lit_q", int'(quotient), eq);
    chk("lit_r", int'(remainder), er);
    chk("lit_dz", int'(divzero), edz);
    chk("lit_latency", lat, elat);
    chk("lit_busy_cycles", nb, ebusy);
  endtask

  initial begin
    int lat, nb;
    resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dz", int'(divzero), 0);
    chk_en = 1;
    resetn = 1'b1;
    @(negedge clk);

    div_lit(13, 3, 4, 1, 0, 5, 4);
    div_lit(15, 1, 15, 0, 0, 5, 4);
    div_lit(2, 9, 0, 2, 0, 5, 4);
    div_lit(15, 15, 1, 0, 0, 5, 4);
    div_lit(0, 5, 0, 0, 0, 5, 4);
    div_lit(7, 0, 15, 7, 1, 1, 0);
    div_lit(8, 2, 4, 0, 0, 5, 4);
    @(negedge clk);

    // Start pulse during RUN is ignored.
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("ign_q", int'(quotient), 2);
    chk("ign_r", int'(remainder), 2);
    // Start held high in DONE is accepted back-to-back.
    div_lit(9, 2, 4, 1, 0, 5, 4);
    @(negedge clk);

    // Reset on the second RUN edge aborts the operation.
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    repeat (6) @(negedge clk);
    div_lit(14, 3, 4, 2, 0, 5, 4);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      resetn   = ($urandom_range(0, 80) != 0);
    end
    @(negedge clk);
    start = 1'b0; resetn = 1'b1;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
